// File: rtl/rv32i_irq_pkg.sv
// Shared constants for the rv32i interrupt controller: register offsets,
// claim-ID width and the largest supported source count.
package rv32i_irq_pkg;

   localparam int IRQ_MAX_SRC = 8;
   localparam int IRQ_ID_W    = 4;

   localparam logic [3:0] IRQ_PENDING   = 4'h0;
   localparam logic [3:0] IRQ_ENABLE    = 4'h1;
   localparam logic [3:0] IRQ_THRESHOLD = 4'h2;
   localparam logic [3:0] IRQ_CLAIM     = 4'h3;
   localparam logic [3:0] IRQ_EDGE      = 4'h4;
   localparam logic [3:0] IRQ_PRIO_BASE = 4'h8;

endpackage

// File: rtl/rv32i_irq_prio_select.sv
// Picks the highest-priority candidate; equal priorities resolve to the
// lowest ID. win_id is 0 when no candidate is present.
module rv32i_irq_prio_select
   import rv32i_irq_pkg::*;
#(
   parameter int NUM_SRC   = IRQ_MAX_SRC,
   parameter int PRIO_BITS = 3
) (
   input  logic [NUM_SRC-1:0]                cand,
   input  logic [NUM_SRC-1:0][PRIO_BITS-1:0] prio,
   output logic [IRQ_ID_W-1:0]               win_id,
   output logic [PRIO_BITS-1:0]              win_prio
);

   always_comb begin
      win_id   = '0;
      win_prio = '0;
      // Strictly-greater compare keeps the earlier (lower) ID on a tie.
      for (int k = 0; k < NUM_SRC; k++) begin
         if (cand[k] && (win_id == '0 || prio[k] > win_prio)) begin
            win_id   = IRQ_ID_W'(k + 1);
            win_prio = prio[k];
         end
      end
   end

endmodule

// File: rtl/rv32i_irq_ctrl.sv
// Platform interrupt controller: per-source gateway, enable, priority and
// threshold, claim/complete. Define IRQ_EDGE_DETECT_EN for edge-triggered sources.
module rv32i_irq_ctrl
   import rv32i_irq_pkg::*;
#(
   parameter int NUM_SRC   = IRQ_MAX_SRC,
   parameter int PRIO_BITS = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_SRC-1:0] i_src,
   input  logic               i_stb,
   input  logic               i_wr_en,
   input  logic [3:0]         i_addr,
   input  logic [31:0]        i_wdata,
   output logic [31:0]        o_rdata,
   output logic               o_ack,
   output logic               o_external_interrupt
);

   logic [NUM_SRC-1:0]                pending, enable, in_service;
   logic [NUM_SRC-1:0][PRIO_BITS-1:0] prio;
   logic [PRIO_BITS-1:0]              threshold;
   logic [NUM_SRC-1:0]                cand, set, claim_mask, comp_mask;
   logic [IRQ_ID_W-1:0]               win_id, comp_id;
   logic [PRIO_BITS-1:0]              win_prio;
   logic [2:0]                        prio_idx;
   logic                              prio_hit;
   logic                              wr_fire, rd_fire, claim_fire, comp_fire;
   logic [31:0]                       rd_mux;
   logic                              unused_ok;

   // Bus: one-cycle i_stb starts an access; o_ack is high exactly one cycle
   // later with o_rdata valid; writes and claim side effects land on that edge.
   assign wr_fire    = i_stb & i_wr_en;
   assign rd_fire    = i_stb & ~i_wr_en;
   assign claim_fire = rd_fire && (i_addr == IRQ_CLAIM) && (win_id != '0);
   assign comp_fire  = wr_fire && (i_addr == IRQ_CLAIM);
   assign comp_id    = i_wdata[IRQ_ID_W-1:0];
   assign prio_idx   = 3'(i_addr - IRQ_PRIO_BASE);
   assign prio_hit   = (i_addr >= IRQ_PRIO_BASE) && (int'(prio_idx) < NUM_SRC);
   assign unused_ok  = ^{i_wdata, win_prio};

   always_comb begin
      for (int k = 0; k < NUM_SRC; k++) begin
         cand[k]       = pending[k] & enable[k] & ~in_service[k] & (prio[k] > threshold);
         claim_mask[k] = claim_fire && (win_id == IRQ_ID_W'(k + 1));
         comp_mask[k]  = comp_fire && (comp_id == IRQ_ID_W'(k + 1));
      end
   end

   rv32i_irq_prio_select #(
      .NUM_SRC   (NUM_SRC),
      .PRIO_BITS (PRIO_BITS)
   ) u_select (
      .cand     (cand),
      .prio     (prio),
      .win_id   (win_id),
      .win_prio (win_prio)
   );

`ifdef IRQ_EDGE_DETECT_EN
   logic [NUM_SRC-1:0] edge_mode, src_q;

   // Edge sources latch a rising request even while in service.
   assign set = (edge_mode & i_src & ~src_q) | (~edge_mode & i_src & ~in_service);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         edge_mode <= '0;
         src_q     <= '0;
      end else begin
         src_q <= i_src;
         if (wr_fire && i_addr == IRQ_EDGE)
            edge_mode <= i_wdata[NUM_SRC-1:0];
      end
   end
`else
   assign set = i_src & ~in_service;
`endif

   always_comb begin
      rd_mux = '0;
      case (i_addr)
         IRQ_PENDING:   rd_mux[NUM_SRC-1:0]   = pending;
         IRQ_ENABLE:    rd_mux[NUM_SRC-1:0]   = enable;
         IRQ_THRESHOLD: rd_mux[PRIO_BITS-1:0] = threshold;
         IRQ_CLAIM:     rd_mux[IRQ_ID_W-1:0]  = win_id;
         IRQ_EDGE: begin
`ifdef IRQ_EDGE_DETECT_EN
            rd_mux[NUM_SRC-1:0] = edge_mode;
`else
            rd_mux = '0;
`endif
         end
         default: if (prio_hit) rd_mux[PRIO_BITS-1:0] = prio[prio_idx];
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ack                <= 1'b0;
         o_rdata              <= '0;
         o_external_interrupt <= 1'b0;
         pending              <= '0;
         enable               <= '0;
         in_service           <= '0;
         threshold            <= '0;
         prio                 <= '0;
      end else begin
         o_ack                <= i_stb;
         o_rdata              <= rd_fire ? rd_mux : '0;
         o_external_interrupt <= |cand;
         // A claim overrides a same-cycle set so the winner does not re-pend.
         pending              <= (pending | set) & ~claim_mask;
         in_service           <= (in_service & ~comp_mask) | claim_mask;
         if (wr_fire) begin
            case (i_addr)
               IRQ_ENABLE:    enable    <= i_wdata[NUM_SRC-1:0];
               IRQ_THRESHOLD: threshold <= i_wdata[PRIO_BITS-1:0];
               default: if (prio_hit) prio[prio_idx] <= i_wdata[PRIO_BITS-1:0];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rv32i_irq_ctrl.sv
// Directed bench for rv32i_irq_ctrl; expected values are hand-computed.
module tb_rv32i_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  src = '0;
   logic        stb = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ack;
   logic        irq;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   rv32i_irq_ctrl #(
      .NUM_SRC   (8),
      .PRIO_BITS (3)
   ) dut (
      .i_clk                (clk),
      .i_rst                (rst),
      .i_src                (src),
      .i_stb                (stb),
      .i_wr_en              (wr_en),
      .i_addr               (addr),
      .i_wdata              (wdata),
      .o_rdata              (rdata),
      .o_ack                (ack),
      .o_external_interrupt (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the ack edge.
   task automatic bus(input logic wr, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
      stb = 1'b1; wr_en = wr; addr = a; wdata = d;
      @(negedge clk);
      stb = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
      check("ack", {31'd0, ack}, 32'd1);
      rd = rdata;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] r;
      bus(1'b1, a, d, r);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b0, a, 32'd0, r);
      check(tag, r, exp);
   endtask

   task automatic irq_chk(input string tag, input logic exp);
      check(tag, {31'd0, irq}, {31'd0, exp});
   endtask

   initial begin
      // Reset and idle values
      tick(3);
      rst = 1'b0;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      irq_chk("rst_irq", 1'b0);
      rd_chk("rst_pending", 4'h0, 32'd0);
      rd_chk("rst_enable", 4'h1, 32'd0);
      rd_chk("rst_thresh", 4'h2, 32'd0);
      rd_chk("rst_claim", 4'h3, 32'd0);
      rd_chk("rst_edge", 4'h4, 32'd0);
      for (int k = 8; k < 16; k++) rd_chk("rst_prio", 4'(k), 32'd0);
      tick(1);
      check("ack_drop", {31'd0, ack}, 32'd0);
      check("idle_rdata", rdata, 32'd0);

      // Level source ID3: latency, claim, no re-pend while in service, complete
      wr(4'hA, 32'd2);
      wr(4'h1, 32'h04);
      wr(4'h2, 32'd0);
      src = 8'h04;
      tick(1);
      irq_chk("irq_edge1", 1'b0);
      tick(1);
      irq_chk("irq_edge2", 1'b1);
      rd_chk("claim_id3", 4'h3, 32'd3);
      irq_chk("irq_claim_cycle", 1'b1);
      tick(1);
      irq_chk("irq_after_claim", 1'b0);
      tick(3);
      irq_chk("irq_in_service", 1'b0);
      rd_chk("pend_in_service", 4'h0, 32'd0);
      wr(4'h3, 32'd3);
      irq_chk("irq_complete_c0", 1'b0);
      tick(1);
      irq_chk("irq_complete_c1", 1'b0);
      tick(1);
      irq_chk("irq_complete_c2", 1'b1);
      src = 8'h00;
      rd_chk("claim_id3_again", 4'h3, 32'd3);
      wr(4'h3, 32'd3);

      // Equal priorities: lowest ID first
      wr(4'h9, 32'd4);
      wr(4'hC, 32'd4);
      wr(4'h1, 32'h12);
      src = 8'h12;
      tick(1);
      src = 8'h00;
      tick(2);
      rd_chk("pend_2_5", 4'h0, 32'h12);
      irq_chk("irq_2_5", 1'b1);
      rd_chk("claim_first", 4'h3, 32'd2);
      rd_chk("claim_second", 4'h3, 32'd5);
      rd_chk("claim_none", 4'h3, 32'd0);
      rd_chk("pend_after_claims", 4'h0, 32'd0);

      // Ignored completes: ID 0, ID 9, not-in-service ID 3
      src = 8'h04;
      tick(1);
      src = 8'h00;
      tick(1);
      wr(4'h3, 32'd0);
      wr(4'h3, 32'd9);
      wr(4'h3, 32'd3);
      src = 8'h02;
      tick(1);
      src = 8'h00;
      tick(1);
      rd_chk("pend_bad_complete", 4'h0, 32'h04);
      irq_chk("irq_bad_complete", 1'b0);
      wr(4'h3, 32'd2);
      src = 8'h02;
      tick(1);
      src = 8'h00;
      tick(1);
      rd_chk("pend_after_comp2", 4'h0, 32'h06);
      wr(4'h3, 32'd5);
      rd_chk("claim_id2", 4'h3, 32'd2);
      wr(4'h3, 32'd2);

      // Threshold: priority must be strictly above it
      wr(4'hA, 32'd4);
      wr(4'h2, 32'd4);
      wr(4'h1, 32'h04);
      tick(2);
      irq_chk("irq_at_thresh", 1'b0);
      rd_chk("claim_at_thresh", 4'h3, 32'd0);
      rd_chk("pend_zero_claim", 4'h0, 32'h04);
      rd_chk("thresh_rb", 4'h2, 32'd4);
      wr(4'h2, 32'd3);
      irq_chk("irq_thresh_ack", 1'b0);
      tick(1);
      irq_chk("irq_thresh_rise", 1'b1);
      rd_chk("claim_thresh", 4'h3, 32'd3);
      wr(4'h3, 32'd3);

      // Read-only, unmapped and upper-bit behaviour
      wr(4'h0, 32'hFF);
      rd_chk("pend_ro", 4'h0, 32'd0);
      rd_chk("unmapped", 4'h5, 32'd0);
      wr(4'hF, 32'hFFFF_FFFF);
      rd_chk("prio8_rb", 4'hF, 32'd7);
      wr(4'h1, 32'hFFFF_FFA5);
      rd_chk("enable_rb", 4'h1, 32'hA5);

`ifdef IRQ_EDGE_DETECT_EN
      // Edge source ID1 re-pends while in service but cannot win
      wr(4'h4, 32'h01);
      rd_chk("edge_rb", 4'h4, 32'h01);
      wr(4'h8, 32'd1);
      wr(4'h2, 32'd0);
      wr(4'h1, 32'h01);
      src = 8'h01;
      tick(1);
      src = 8'h00;
      tick(1);
      rd_chk("edge_pend", 4'h0, 32'h01);
      rd_chk("edge_claim", 4'h3, 32'd1);
      src = 8'h01;
      tick(1);
      src = 8'h00;
      tick(1);
      rd_chk("edge_repend", 4'h0, 32'h01);
      irq_chk("edge_irq_in_service", 1'b0);
      wr(4'h3, 32'd1);
      irq_chk("edge_irq_c0", 1'b0);
      tick(1);
      irq_chk("edge_irq_c1", 1'b1);
      rd_chk("edge_claim2", 4'h3, 32'd1);
      wr(4'h3, 32'd1);
`else
      wr(4'h4, 32'hFF);
      rd_chk("edge_disabled", 4'h4, 32'd0);
`endif

      // Reset during an access
      stb = 1'b1; wr_en = 1'b0; addr = 4'h1; rst = 1'b1;
      @(negedge clk);
      stb = 1'b0; addr = '0;
      check("rst_mid_ack", {31'd0, ack}, 32'd0);
      check("rst_mid_rdata", rdata, 32'd0);
      irq_chk("rst_mid_irq", 1'b0);
      rst = 1'b0;
      rd_chk("rst_mid_enable", 4'h1, 32'd0);
      rd_chk("rst_mid_prio8", 4'hF, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
